// File: rtl/vec_xform_ctrl_pkg.sv
// Shared types and constants for the vertex transform sequencer.
// Core latency, FSM encoding and the control register bundle.
package vec_xform_ctrl_pkg;

  localparam int DP_LATENCY = 7;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    state_e             state;
    logic [127:0]       mat;
    logic               sgn;
    logic [CNT_W-1:0]   reserved;
    logic [CNT_W-1:0]   inflight;
  } vec_xform_ctrl_registers;

  localparam vec_xform_ctrl_registers vec_xform_ctrl_r_reset = '{
    state:    IDLE,
    mat:      '0,
    sgn:      1'b0,
    reserved: '0,
    inflight: '0
  };

endpackage

// File: rtl/mul_4x4_i8.sv
// 4x4 int8 matrix times 4-vector, 18-bit results.
// Fixed 7-cycle registered pipeline, no stall input.
module mul_4x4_i8 #(
  parameter bit async_reset = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic [127:0] i_m,
  input  logic         i_signed,
  input  logic [7:0]   i_v0,
  input  logic [7:0]   i_v1,
  input  logic [7:0]   i_v2,
  input  logic [7:0]   i_v3,
  output logic [17:0]  o_res0,
  output logic [17:0]  o_res1,
  output logic [17:0]  o_res2,
  output logic [17:0]  o_res3
);

  localparam int LAT = 7;

  function automatic logic [17:0] ext(
    input logic [7:0] x,
    input logic       s
  );
    return s ? {{10{x[7]}}, x} : {10'b0, x};
  endfunction

  logic [7:0]  w_v   [4];
  logic [17:0] w_dot [4];
  logic [17:0] r_pipe [LAT][4];

  assign w_v[0] = i_v0;
  assign w_v[1] = i_v1;
  assign w_v[2] = i_v2;
  assign w_v[3] = i_v3;

  // Modular 18-bit arithmetic is exact for both signed and unsigned ranges
  always_comb begin
    w_dot = '{default: '0};
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_dot[r] = w_dot[r]
          + ext(i_m[8*(4*r+c) +: 8], i_signed)
          * ext(w_v[c], i_signed);
      end
    end
  end

  if (async_reset) begin : g_arst
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        r_pipe <= '{default: '{default: '0}};
      end else begin
        r_pipe[0] <= w_dot;
        for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
  end else begin : g_srst
    always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
        r_pipe <= '{default: '{default: '0}};
      end else begin
        r_pipe[0] <= w_dot;
        for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_res0 = r_pipe[LAT-1][0];
  assign o_res1 = r_pipe[LAT-1][1];
  assign o_res2 = r_pipe[LAT-1][2];
  assign o_res3 = r_pipe[LAT-1][3];

endmodule

// File: rtl/vec_xform_fifo.sv
// Synchronous result FIFO with async active-high reset.
// Read data is zero whenever the FIFO is empty.
module vec_xform_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_re,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign w_rd    = i_re & ~o_empty;
  assign w_wr    = i_we & ((r_cnt != (AW+1)'(DEPTH)) | w_rd);
  assign o_rdata = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/vec_xform_ctrl.sv
// Flow-control sequencer around mul_4x4_i8 with credit-based
// result FIFO and drain-before-reload matrix epochs.
module vec_xform_ctrl
  import vec_xform_ctrl_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [127:0]     i_cfg_m,
  input  logic             i_cfg_signed,
  input  logic             i_vec_valid,
  output logic             o_vec_ready,
  input  logic [31:0]      i_vec,
  input  logic [TAG_W-1:0] i_vec_tag,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [17:0]      o_res0,
  output logic [17:0]      o_res1,
  output logic [17:0]      o_res2,
  output logic [17:0]      o_res3,
  output logic [TAG_W-1:0] o_res_tag,
  output logic             o_busy
);

  localparam int FW  = 4*18 + TAG_W;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  vec_xform_ctrl_registers r_ctl;
  vec_xform_ctrl_registers w_nxt;

  logic                  r_iss_vld;
  logic [31:0]           r_iss_vec;
  logic [TAG_W-1:0]      r_iss_tag;
  logic [DP_LATENCY-1:0] r_sl_vld;
  logic [TAG_W-1:0]      r_sl_tag [DP_LATENCY];

  logic           w_vec_acc;
  logic           w_cfg_acc;
  logic           w_pop;
  logic           w_we;
  logic           w_empty;
  logic [FW-1:0]  w_wdata;
  logic [FW-1:0]  w_rdata;
  logic [FCW-1:0] w_fcnt;
  logic [17:0]    w_res0;
  logic [17:0]    w_res1;
  logic [17:0]    w_res2;
  logic [17:0]    w_res3;

  assign o_vec_ready = (r_ctl.state == RUN)
    && (r_ctl.reserved < CNT_W'(FIFO_DEPTH));
  assign o_cfg_ready = (r_ctl.state == IDLE)
    || ((r_ctl.state == DRAIN) && (r_ctl.inflight == '0));

  assign w_vec_acc = i_vec_valid & o_vec_ready;
  assign w_cfg_acc = i_cfg_valid & o_cfg_ready;
  assign w_pop     = o_res_valid & i_res_ready;
  assign w_we      = r_sl_vld[DP_LATENCY-1];

  always_comb begin
    w_nxt = r_ctl;
    unique case (r_ctl.state)
      IDLE, DRAIN: begin
        if (w_cfg_acc) begin
          w_nxt.mat   = i_cfg_m;
          w_nxt.sgn   = i_cfg_signed;
          w_nxt.state = RUN;
        end
      end
      RUN: begin
        if (i_cfg_valid) w_nxt.state = DRAIN;
      end
      default: w_nxt.state = IDLE;
    endcase
    unique case ({w_vec_acc, w_pop})
      2'b10:   w_nxt.reserved = r_ctl.reserved + 1'b1;
      2'b01:   w_nxt.reserved = r_ctl.reserved - 1'b1;
      default: w_nxt.reserved = r_ctl.reserved;
    endcase
    unique case ({w_vec_acc, w_we})
      2'b10:   w_nxt.inflight = r_ctl.inflight + 1'b1;
      2'b01:   w_nxt.inflight = r_ctl.inflight - 1'b1;
      default: w_nxt.inflight = r_ctl.inflight;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ctl <= vec_xform_ctrl_r_reset;
    else       r_ctl <= w_nxt;
  end

  // Issue register feeds the core; the shift line mirrors core occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_iss_vld <= 1'b0;
      r_iss_vec <= '0;
      r_iss_tag <= '0;
      r_sl_vld  <= '0;
      r_sl_tag  <= '{default: '0};
    end else begin
      r_iss_vld <= w_vec_acc;
      if (w_vec_acc) begin
        r_iss_vec <= i_vec;
        r_iss_tag <= i_vec_tag;
      end
      r_sl_vld    <= {r_sl_vld[DP_LATENCY-2:0], r_iss_vld};
      r_sl_tag[0] <= r_iss_tag;
      for (int i = 1; i < DP_LATENCY; i++) r_sl_tag[i] <= r_sl_tag[i-1];
    end
  end

  mul_4x4_i8 #(
    .async_reset (1'b1)
  ) u_core (
    .i_clk    (i_clk),
    .i_nrst   (~i_rst),
    .i_m      (r_ctl.mat),
    .i_signed (r_ctl.sgn),
    .i_v0     (r_iss_vec[7:0]),
    .i_v1     (r_iss_vec[15:8]),
    .i_v2     (r_iss_vec[23:16]),
    .i_v3     (r_iss_vec[31:24]),
    .o_res0   (w_res0),
    .o_res1   (w_res1),
    .o_res2   (w_res2),
    .o_res3   (w_res3)
  );

  assign w_wdata = {w_res0, w_res1, w_res2, w_res3,
                    r_sl_tag[DP_LATENCY-1]};

  vec_xform_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_wdata (w_wdata),
    .i_re    (i_res_ready),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_count (w_fcnt)
  );

  assign o_res_valid = ~w_empty;
  assign {o_res0, o_res1, o_res2, o_res3, o_res_tag} = w_rdata;
  assign o_busy = (r_ctl.inflight != '0) || (w_fcnt != '0);

endmodule

// File: tb/tb_vec_xform_ctrl.sv
// Scoreboard bench for vec_xform_ctrl: random vectors against an
// arithmetic reference model, checked by an independent monitor.
module tb_vec_xform_ctrl;

  localparam int TAG_W = 4;
  localparam int DEPTH = 16;
  localparam logic [127:0] IDENT =
    128'h01000000_00010000_00000100_00000001;
  localparam logic [127:0] IDENT2 =
    128'h02000000_00020000_00000200_00000002;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_cfg_valid = 1'b0;
  logic             o_cfg_ready;
  logic [127:0]     i_cfg_m = '0;
  logic             i_cfg_signed = 1'b0;
  logic             i_vec_valid = 1'b0;
  logic             o_vec_ready;
  logic [31:0]      i_vec = '0;
  logic [TAG_W-1:0] i_vec_tag = '0;
  logic             o_res_valid;
  logic             i_res_ready = 1'b1;
  logic [17:0]      o_res0, o_res1, o_res2, o_res3;
  logic [TAG_W-1:0] o_res_tag;
  logic             o_busy;

  always #5 clk = ~clk;

  vec_xform_ctrl #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cfg_valid  (i_cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .i_cfg_m      (i_cfg_m),
    .i_cfg_signed (i_cfg_signed),
    .i_vec_valid  (i_vec_valid),
    .o_vec_ready  (o_vec_ready),
    .i_vec        (i_vec),
    .i_vec_tag    (i_vec_tag),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res0       (o_res0),
    .o_res1       (o_res1),
    .o_res2       (o_res2),
    .o_res3       (o_res3),
    .o_res_tag    (o_res_tag),
    .o_busy       (o_busy)
  );

  typedef struct packed {
    logic [71:0] res;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t         q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           tb_res = 0;
  int           last_acc = -100;
  int           n_pop = 0;
  bit           exact_lat = 1'b0;
  bit           saw_full = 1'b0;
  bit           rnd_ready = 1'b0;
  logic [127:0] m_mat = '0;
  bit           m_sgn = 1'b0;
  bit           prev_hold = 1'b0;
  logic [75:0]  prev_data = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  // Reference: plain integer dot products, truncated to 18 bits
  function automatic logic [71:0] model(input logic [127:0] m,
                                        input bit s,
                                        input logic [31:0] v);
    logic [71:0] o;
    logic [7:0]  me, ve;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      int acc;
      acc = 0;
      for (int c = 0; c < 4; c++) begin
        int a, b;
        me = m[8*(4*r+c) +: 8];
        ve = v[8*c +: 8];
        a = s ? int'($signed(me)) : int'(me);
        b = s ? int'($signed(ve)) : int'(ve);
        acc += a * b;
      end
      o[18*(3-r) +: 18] = acc[17:0];
    end
    return o;
  endfunction

  always @(negedge clk) begin
    logic [75:0] cur;
    exp_t e;
    cur = {o_res0, o_res1, o_res2, o_res3, o_res_tag};
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        chk("hold", {o_res_valid, cur}, {1'b1, prev_data});
      if (i_vec_valid && o_vec_ready) begin
        e.res = model(m_mat, m_sgn, i_vec);
        e.tag = i_vec_tag;
        e.acc = cyc + 1;
        q.push_back(e);
        tb_res++;
        last_acc = cyc + 1;
        chk("credit", tb_res <= DEPTH, 1'b1);
      end else if (tb_res >= DEPTH) begin
        chk("ready_full", o_vec_ready, 1'b0);
        saw_full = 1'b1;
      end
      if (o_res_valid && i_res_ready) begin
        tb_res--;
        n_pop++;
        if (q.size() == 0) begin
          chk("extra_result", cur, 76'h0);
        end else begin
          e = q.pop_front();
          chk("data", cur, {e.res, e.tag});
          if (exact_lat) chk("latency", cyc - e.acc, 8);
          else chk("latency_min", (cyc - e.acc) >= 8, 1'b1);
        end
      end
      prev_hold = o_res_valid && !i_res_ready;
      prev_data = cur;
    end
  end

  task automatic load_cfg(input logic [127:0] m, input bit s,
                          input bit chk_drain);
    int n;
    n = 0;
    i_cfg_valid  = 1'b1;
    i_cfg_m      = m;
    i_cfg_signed = s;
    forever begin
      @(negedge clk);
      if (chk_drain)
        chk("cfg_drain", o_cfg_ready, cyc >= last_acc + 8);
      if (o_cfg_ready) break;
      n++;
      if (n > 300) begin
        chk("cfg_timeout", 1'b0, 1'b1);
        break;
      end
    end
    m_mat = m;
    m_sgn = s;
    @(posedge clk);
    #1 i_cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input logic [3:0] t,
                      output int stalls);
    i_vec_valid = 1'b1;
    i_vec       = v;
    i_vec_tag   = t;
    stalls      = 0;
    forever begin
      @(negedge clk);
      if (o_vec_ready) break;
      stalls++;
      if (stalls > 2000) begin
        chk("vec_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    i_res_ready = 1'b1;
    while (q.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    repeat (12) @(posedge clk);
    #1;
    chk("drained", q.size(), 0);
  endtask

  initial begin
    int st, tot;
    logic [127:0] rm;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", o_cfg_ready, 1'b1);
    chk("rst_vec_ready", o_vec_ready, 1'b0);
    chk("rst_res_valid", o_res_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_data", {o_res0, o_res1, o_res2, o_res3, o_res_tag}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    exact_lat = 1'b1;
    load_cfg(IDENT, 1'b0, 1'b0);
    chk("cfg_to_ready", o_vec_ready, 1'b1);
    send(32'h04030201, 4'd5, st);
    i_vec_valid = 1'b0;
    drain();

    load_cfg({16{8'hFF}}, 1'b1, 1'b0);
    send(32'h04030201, 4'd1, st);
    i_vec_valid = 1'b0;
    drain();
    load_cfg({16{8'hFF}}, 1'b0, 1'b0);
    send(32'hFFFFFFFF, 4'd2, st);
    i_vec_valid = 1'b0;
    drain();

    exact_lat = 1'b0;
    rm = {$urandom, $urandom, $urandom, $urandom};
    load_cfg(rm, 1'($urandom % 2), 1'b0);
    i_res_ready = 1'b0;
    rnd_ready = 1'b1;
    fork
      begin
        repeat (25) @(posedge clk);
        while (rnd_ready) begin
          @(posedge clk);
          #1 if (rnd_ready) i_res_ready = 1'($urandom % 2);
        end
      end
    join_none
    n_pop = 0;
    for (int i = 0; i < 40; i++) send($urandom, 4'(i % 16), st);
    i_vec_valid = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    drain();
    chk("bp_count", n_pop, 40);
    chk("bp_saw_full", saw_full, 1'b1);

    exact_lat = 1'b1;
    rm = {$urandom, $urandom, $urandom, $urandom};
    load_cfg(rm, 1'b1, 1'b0);
    tot = 0;
    n_pop = 0;
    for (int i = 0; i < 100; i++) begin
      send($urandom, 4'($urandom), st);
      tot += st;
    end
    i_vec_valid = 1'b0;
    drain();
    chk("tp_stalls", tot, 0);
    chk("tp_count", n_pop, 100);

    load_cfg(IDENT, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send($urandom, 4'(i), st);
    i_vec_valid = 1'b0;
    load_cfg(IDENT2, 1'b0, 1'b1);
    send(32'h04030201, 4'd9, st);
    i_vec_valid = 1'b0;
    drain();

    exact_lat = 1'b0;
    i_res_ready = 1'b0;
    for (int i = 0; i < 8; i++) send($urandom, 4'(i), st);
    i_vec_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send($urandom, 4'(i), st);
    i_vec_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_res_valid", o_res_valid, 1'b0);
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_cfg_ready", o_cfg_ready, 1'b1);
    chk("arst_vec_ready", o_vec_ready, 1'b0);
    q.delete();
    tb_res = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    i_res_ready = 1'b1;
    exact_lat = 1'b1;
    load_cfg(IDENT, 1'b0, 1'b0);
    send($urandom, 4'd3, st);
    i_vec_valid = 1'b0;
    drain();
    repeat (20) @(posedge clk);
    #1;
    chk("final_busy", o_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
